aer_link_arbiter: RTL and testbench

// - Shares the 10-bit AER input link of the SNN core between two requesters: the ROC encoder

---
 rtl/aer_link_arbiter.sv | 149 ++++++++++++++
 tb/tb_aer_link_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_link_arbiter.sv
// rtl/aer_link_arbiter.sv - two-requester arbiter driving the core's 4-phase AER input link
// Optional round-robin arbitration via ARB_ROUND_ROBIN_EN; fixed HOST priority otherwise.
module aer_link_arbiter #(
    parameter int ACK_TIMEOUT = 1023,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_BITS    = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ENC_REQ,
    input  logic [9:0]          ENC_ADDR,
    output logic                ENC_GNT,
    input  logic                HOST_REQ,
    input  logic [9:0]          HOST_ADDR,
    output logic                HOST_GNT,
    output logic                AERIN_CTRL_BUSY,
    output logic [9:0]          AEROUT_ADDR,
    output logic                AEROUT_REQ,
    input  logic                AEROUT_ACK,
    output logic [CNT_BITS-1:0] EVENTS_SENT,
    output logic                ACK_ERR,
    input  logic                CLR_CNT
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]       TMO_LIMIT = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0]       TMR_ONE   = TW'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
    localparam logic [3:0]          GAP_LAST  = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } state_t;

    state_t        r_state;
    logic          r_ack_m;
    logic          r_ack_s;
    logic [TW-1:0] r_tmr;
    logic [3:0]    r_gap;
    logic          r_abort;

    logic [TW-1:0] w_tmr_nxt;
    logic          w_timeout;
    logic          w_pick_host;

    // The timer holds the number of cycles already waited in the current phase.
    assign w_tmr_nxt = r_tmr + TMR_ONE;
    assign w_timeout = (w_tmr_nxt == TMO_LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_host;
    assign w_pick_host = HOST_REQ && (!ENC_REQ || !r_last_host);
`else
    assign w_pick_host = HOST_REQ;
`endif

    assign AERIN_CTRL_BUSY = (r_state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_ack_m     <= 1'b0;
            r_ack_s     <= 1'b0;
            r_tmr       <= '0;
            r_gap       <= '0;
            r_abort     <= 1'b0;
            ENC_GNT     <= 1'b0;
            HOST_GNT    <= 1'b0;
            AEROUT_ADDR <= '0;
            AEROUT_REQ  <= 1'b0;
            EVENTS_SENT <= '0;
            ACK_ERR     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_host <= 1'b0;
`endif
        end else begin
            r_ack_m  <= AEROUT_ACK;
            r_ack_s  <= r_ack_m;
            ENC_GNT  <= 1'b0;
            HOST_GNT <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ENC_REQ || HOST_REQ) begin
                        if (w_pick_host) begin
                            HOST_GNT    <= 1'b1;
                            AEROUT_ADDR <= HOST_ADDR;
                        end else begin
                            ENC_GNT     <= 1'b1;
                            AEROUT_ADDR <= ENC_ADDR;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_host <= w_pick_host;
`endif
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    AEROUT_REQ <= 1'b1;
                    r_tmr      <= '0;
                    r_abort    <= 1'b0;
                    r_state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (r_ack_s || w_timeout) begin
                        AEROUT_REQ <= 1'b0;
                        r_tmr      <= '0;
                        r_state    <= S_WAIT_LO;
                        if (!r_ack_s) begin
                            ACK_ERR <= 1'b1;
                            r_abort <= 1'b1;
                        end
                    end else begin
                        r_tmr <= w_tmr_nxt;
                    end
                end
                S_WAIT_LO: begin
                    if (!r_ack_s || w_timeout) begin
                        if (r_ack_s) begin
                            ACK_ERR <= 1'b1;
                        end else if (!r_abort && (EVENTS_SENT != '1)) begin
                            EVENTS_SENT <= EVENTS_SENT + CNT_ONE;
                        end
                        r_gap   <= '0;
                        r_state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        r_tmr <= w_tmr_nxt;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A clear in the same cycle as a completed handshake leaves the counter at zero.
            if (CLR_CNT) begin
                EVENTS_SENT <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aer_link_arbiter.sv
// tb/tb_aer_link_arbiter.sv - directed and randomized checks of aer_link_arbiter
// Built with or without ARB_ROUND_ROBIN_EN; the reference arbitration follows the same macro.
module tb_aer_link_arbiter;

    localparam int TMO  = 15;
    localparam int GAP  = 3;
    localparam int CNTW = 4;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            ENC_REQ, HOST_REQ;
    logic [9:0]      ENC_ADDR, HOST_ADDR;
    logic            ENC_GNT, HOST_GNT;
    logic            AERIN_CTRL_BUSY;
    logic [9:0]      AEROUT_ADDR;
    logic            AEROUT_REQ;
    logic            AEROUT_ACK;
    logic [CNTW-1:0] EVENTS_SENT;
    logic            ACK_ERR;
    logic            CLR_CNT;

    aer_link_arbiter #(.ACK_TIMEOUT(TMO), .GAP_CYCLES(GAP), .CNT_BITS(CNTW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ENC_REQ(ENC_REQ), .ENC_ADDR(ENC_ADDR), .ENC_GNT(ENC_GNT),
        .HOST_REQ(HOST_REQ), .HOST_ADDR(HOST_ADDR), .HOST_GNT(HOST_GNT),
        .AERIN_CTRL_BUSY(AERIN_CTRL_BUSY), .AEROUT_ADDR(AEROUT_ADDR),
        .AEROUT_REQ(AEROUT_REQ), .AEROUT_ACK(AEROUT_ACK),
        .EVENTS_SENT(EVENTS_SENT), .ACK_ERR(ACK_ERR), .CLR_CNT(CLR_CNT)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         ack_dly = 2;
    bit         no_ack = 1'b0;
    logic [7:0] hist = '0;
    logic [9:0] enc_q[$];
    logic [9:0] host_q[$];
    int         gnt_log[$];
    int         gnt_cyc[$];
    logic [9:0] last_gnt_addr = '0;
    bit         last_host = 1'b0;
    logic       prev_req = 1'b0;
    int         req_rises = 0;
    int         model_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ENC_REQ   = (enc_q.size() != 0);
        ENC_ADDR  = ENC_REQ ? enc_q[0] : 10'h0;
        HOST_REQ  = (host_q.size() != 0);
        HOST_ADDR = HOST_REQ ? host_q[0] : 10'h0;
    endtask

    // One cycle: core ack model, grant scoreboard, address check, requester update.
    task automatic step();
        bit hr, er, exp_host;
        @(negedge CLK);
        cyc++;
        hist = {hist[6:0], AEROUT_REQ};
        AEROUT_ACK = no_ack ? 1'b0 : hist[ack_dly];
        if (ENC_GNT || HOST_GNT) begin
            hr = (host_q.size() != 0);
            er = (enc_q.size() != 0);
`ifdef ARB_ROUND_ROBIN_EN
            exp_host = hr && (!er || !last_host);
`else
            exp_host = hr;
`endif
            chk("gnt_winner", HOST_GNT, exp_host);
            chk("gnt_onehot", ENC_GNT ^ HOST_GNT, 1'b1);
            if (HOST_GNT && hr) last_gnt_addr = host_q.pop_front();
            else if (ENC_GNT && er) last_gnt_addr = enc_q.pop_front();
            last_host = HOST_GNT;
            gnt_log.push_back(int'(HOST_GNT));
            gnt_cyc.push_back(cyc);
        end
        if (AEROUT_REQ && !prev_req) begin
            req_rises++;
            chk("addr_at_req", AEROUT_ADDR, last_gnt_addr);
        end
        prev_req = AEROUT_REQ;
        drive();
    endtask

    task automatic run_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (enc_q.size() == 0 && host_q.size() == 0 && !AERIN_CTRL_BUSY && !AEROUT_ACK) break;
            step();
        end
        chk({tag, "_pending"}, enc_q.size() + host_q.size(), 0);
        chk({tag, "_busy"}, AERIN_CTRL_BUSY, 1'b0);
    endtask

    task automatic wait_req(input logic lvl, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (AEROUT_REQ === lvl) break;
            step();
        end
        chk("wait_req", AEROUT_REQ, lvl);
    endtask

    task automatic wait_ack(input logic lvl, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (AEROUT_ACK === lvl) break;
            step();
        end
        chk("wait_ack", AEROUT_ACK, lvl);
    endtask

    task automatic clear_log();
        gnt_log.delete();
        gnt_cyc.delete();
        req_rises = 0;
    endtask

    initial begin
        int n;
        RST_N = 1'b0;
        CLR_CNT = 1'b0;
        AEROUT_ACK = 1'b0;
        drive();
        repeat (3) step();
        chk("rst_busy", AERIN_CTRL_BUSY, 1'b0);
        chk("rst_req", AEROUT_REQ, 1'b0);
        chk("rst_addr", AEROUT_ADDR, 10'h0);
        chk("rst_cnt", EVENTS_SENT, 0);
        chk("rst_err", ACK_ERR, 1'b0);
        chk("rst_gnt", {ENC_GNT, HOST_GNT}, 2'b00);
        RST_N = 1'b1;
        last_host = 1'b0;

        // single encoder event
        clear_log();
        enc_q.push_back(10'h1FF);
        drive();
        run_done("single", 100);
        model_cnt = 1;
        chk("single_gnts", gnt_log.size(), 1);
        chk("single_enc", gnt_log[0], 0);
        chk("single_rises", req_rises, 1);
        chk("single_addr", AEROUT_ADDR, 10'h1FF);
        chk("single_cnt", EVENTS_SENT, model_cnt);
        chk("single_err", ACK_ERR, 1'b0);

        // back-to-back encoder events: grant spacing includes the idle gap
        clear_log();
        enc_q.push_back(10'($urandom));
        enc_q.push_back(10'($urandom));
        drive();
        run_done("gap", 100);
        model_cnt += 2;
        chk("gap_gnts", gnt_log.size(), 2);
        chk("gap_period", gnt_cyc[1] - gnt_cyc[0], 2 + 2 * (ack_dly + 3) + GAP);
        chk("gap_cnt", EVENTS_SENT, model_cnt);

        // contention with random addresses and core latency
        clear_log();
        ack_dly = int'($urandom_range(4, 1));
        for (int i = 0; i < 4; i++) begin
            enc_q.push_back(10'($urandom));
            host_q.push_back(10'($urandom));
        end
        drive();
        run_done("arb", 400);
        model_cnt = (model_cnt + 8 > 15) ? 15 : model_cnt + 8;
        chk("arb_gnts", gnt_log.size(), 8);
        chk("arb_rises", req_rises, 8);
        chk("arb_cnt", EVENTS_SENT, model_cnt);

        // core never acknowledges
        ack_dly = 2;
        no_ack = 1'b1;
        enc_q.push_back(10'($urandom));
        drive();
        wait_req(1'b1, 50);
        n = 0;
        do begin
            step();
            n++;
        end while (AEROUT_REQ && n < 50);
        chk("tmo_len", n, TMO);
        run_done("tmo", 100);
        chk("tmo_err", ACK_ERR, 1'b1);
        chk("tmo_cnt", EVENTS_SENT, model_cnt);
        no_ack = 1'b0;
        enc_q.push_back(10'($urandom));
        drive();
        run_done("tmo_next", 100);
        model_cnt++;
        chk("tmo_next_cnt", EVENTS_SENT, model_cnt);
        chk("tmo_err_sticky", ACK_ERR, 1'b1);

        // reset while waiting for the ack to rise
        no_ack = 1'b1;
        enc_q.push_back(10'($urandom));
        drive();
        wait_req(1'b1, 50);
        repeat (3) step();
        RST_N = 1'b0;
        enc_q.delete();
        drive();
        step();
        chk("mid_rst_req", AEROUT_REQ, 1'b0);
        chk("mid_rst_busy", AERIN_CTRL_BUSY, 1'b0);
        chk("mid_rst_cnt", EVENTS_SENT, 0);
        chk("mid_rst_err", ACK_ERR, 1'b0);
        RST_N = 1'b1;
        no_ack = 1'b0;
        hist = '0;
        last_host = 1'b0;
        model_cnt = 0;

        // counter saturation
        clear_log();
        for (int i = 0; i < 17; i++) enc_q.push_back(10'($urandom));
        drive();
        run_done("sat", 17 * 25);
        chk("sat_gnts", gnt_log.size(), 17);
        chk("sat_cnt", EVENTS_SENT, 15);

        CLR_CNT = 1'b1;
        step();
        CLR_CNT = 1'b0;
        chk("clr_cnt", EVENTS_SENT, 0);

        // clear coincident with the completing handshake
        enc_q.push_back(10'($urandom));
        drive();
        wait_ack(1'b1, 50);
        wait_ack(1'b0, 50);
        step();
        step();
        CLR_CNT = 1'b1;
        step();
        CLR_CNT = 1'b0;
        run_done("clr_inc", 100);
        chk("clr_wins", EVENTS_SENT, 0);
        enc_q.push_back(10'($urandom));
        drive();
        run_done("after_clr", 100);
        chk("after_clr_cnt", EVENTS_SENT, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
